virtual_tm1638_panel_renderer: RTL and testbench
================================================

# virtual_tm1638_panel_renderer

Frame-synchronised, pipelined renderer for a virtual TM1638 front panel on the VGA/HDMI pixel stream. It has w_digit seven-segment digits with decimal point, 8 LEDs and w_keys keys. The block captures multiplexed segment writes and snapshots all panel state once per frame, so the image never tears mid-frame. It adds per-digit blink, key-press hold and dim "ghost" segments, and outputs multi-bit colour. It sits between the lab's tm1638 driver signals and the board's pixel output, fed by the display controller's x/y/display_on/frame_start.

## Interface
- w_digit, 8: number of digits; digit i is drawn with digit 0 rightmost.
- w_keys, 8: number of keys; must be ≤ w_digit.
- screen_width, 640: visible width in pixels.
- screen_height, 480: visible height in pixels.
- w_x, $clog2(screen_width): x width.
- w_y, $clog2(screen_height): y width.
- w_color, 4: bits per colour channel.
- blink_frames, 30: frames per blink half-period; must be ≥ 1.
- key_hold_frames, 8: frames a key stays lit after release; must be ≥ 1.

Ports (clock is clk; reset is asynchronous, active-low, named rst):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- hgfedcba  in  8  segment pattern; bit0 = a … bit6 = g, bit7 = h (dp).
- digit  in  w_digit  one-hot or multi-hot digit strobe.
- ledr  in  8  LED states.
- keys  in  w_keys  raw key states.
- blink  in  w_digit  per-digit blink enable.
- ghost_en  in  1  draw unlit segment cells at level 1.
- x  in  w_x  pixel column.
- y  in  w_y  pixel row.
- display_on  in  1  pixel is in the visible area.
- frame_start  in  1  one-cycle pulse before the first pixel of a frame.
- red, green, blue  out  w_color each  pixel colour.
- rgb_valid  out  1  display_on delayed to align with the colour outputs.

## Operation
- Capture: for every i with digit[i]=1, seg_live[i] <= hgfedcba, every cycle. Reset value is 0.
- Snapshot at frame_start:
  - seg_frame <= seg_live, led_frame <= ledr, blink_frame <= blink.
  - A write coinciding with frame_start is not in this snapshot; it appears in the next frame.
- Key hold: per key there is a counter of width $clog2(key_hold_frames+1). At frame_start:
  - keys[k]=1 → load key_hold_frames;
  - else, if nonzero → decrement.
  - The key is shown while its counter ≠ 0.
- Blink:
  - A frame counter runs 0..blink_frames-1 and advances on frame_start. On wrap, phase toggles.
  - phase=1 means visible. Reset: counter 0, phase 1.
  - While phase=0, segments and dp of digits with blink_frame[i]=1 are blanked. Blink does not affect the LED, separator or key rows.
- Geometry (all constants elaborated):
  - cellsx = 8*w_digit+3, cellsy = 16.
  - s = $clog2(screen_width/cellsx)-1.
  - offx = (screen_width-(cellsx<<s))/2, offy = (screen_height-(cellsy<<s))/2.
- Cell mapping:
  - cx = (x-offx)>>s and cy = (y-offy)>>s; subtraction is unsigned in w_x / w_y bits, so pixels left of or above the panel wrap and land out of range.
  - dx = (cx>>2)+((cx+1)>>2), dy likewise.
  - The grid is valid when dx < 4*w_digit+1 and dy < 8.
- Grid layout (digit i occupies columns c0+1..c0+4 with c0 = (w_digit-1-i)*4):
  - row 0 LEDs at cols c0+1..c0+3;
  - row 1 separator, always lit, at cols 1..4*w_digit-1;
  - row 2 keys at c0+1..c0+3;
  - a (c0+2,3), f (c0+1,4), b (c0+3,4), g (c0+2,5), e (c0+1,6), c (c0+3,6), d (c0+2,7), h (c0+4,7).
- Colour:
  - A lit cell is all-ones on each enabled channel. Row 0 is red+green. Row 2 is red+blue. All other rows are white.
  - An unlit segment, LED or key position with ghost_en=1 outputs the value 1 on the same enabled channels.
  - Any other cell, out-of-grid pixel, or rgb_valid=0 outputs 0.

## Timing
- Two-stage pipeline:
  - stage 1 registers dx, dy, in-range and display_on;
  - stage 2 registers the colour and rgb_valid.
- Latency is exactly 2 clk from x/y/display_on to red/green/blue/rgb_valid. Throughput is one pixel per clk.
- Snapshot state changes on the clk edge sampling frame_start. The pixel presented with frame_start already uses the new snapshot.
- Reset (asserted any time, including mid-frame) zeroes all outputs, pipeline registers, seg_live/seg_frame, led_frame, key counters and the blink counter, and sets phase=1. Outputs are 0 immediately, not at the next edge.

## Test plan
- Defaults. Set hgfedcba=0x01, digit=0x80, pulse frame_start. Drive x=84, y=232, display_on=1 → after 2 clk, red=green=blue=0xF, rgb_valid=1. Clear the pattern and pulse frame_start → 0 (or 1 per channel with ghost_en=1).
- ledr=0x01 with frame_start, pixel (524,180) → red=0xF, green=0xF, blue=0. Pixel (10,10) → all 0.
- Tear-free update. Write digit 7 = 0x00 mid-frame → pixel (84,232) stays 0xF until the next frame_start. Write coinciding with frame_start → old value is kept for that frame.
- Key hold. keys[0]=1 for one frame_start, then 0 → key 0 cells lit for exactly 8 frames, dark on the 9th.
- Blink. blink[7]=1, blink_frames=2 → segment a of digit 7 is visible for 2 frames, blank for 2, repeating. LED row is unaffected.
- Async reset asserted mid-line → outputs 0 with no clock edge. After release, the first frame shows a blank panel with only the separator (row 1) lit white.

Source files
------------

// File: rtl/virtual_tm1638_panel_renderer.sv
`timescale 1ns/1ps
// virtual_tm1638_panel_renderer
//
// Draws a virtual TM1638 front panel into a VGA/HDMI pixel stream: w_digit
// seven-segment digits with decimal point, 8 LEDs and w_keys keys. Segment
// writes are captured continuously and snapshotted once per frame, so a
// frame never tears. Also provides per-digit blink, key-press hold and
// dim "ghost" cells for unlit positions.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   hgfedcba, digit    multiplexed segment pattern and digit strobe
//   ledr, keys, blink  LED states, raw keys, per-digit blink enables
//   ghost_en           draw unlit segment/LED/key cells at level 1
//   x, y, display_on   pixel position and visible-area flag
//   frame_start        one-cycle pulse ahead of the first pixel of a frame
//   red, green, blue   pixel colour, two clocks after x/y/display_on
//   rgb_valid          display_on aligned with the colour outputs
module virtual_tm1638_panel_renderer #(
  parameter int w_digit         = 8,
  parameter int w_keys          = 8,
  parameter int screen_width    = 640,
  parameter int screen_height   = 480,
  parameter int w_x             = $clog2(screen_width),
  parameter int w_y             = $clog2(screen_height),
  parameter int w_color         = 4,
  parameter int blink_frames    = 30,
  parameter int key_hold_frames = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         hgfedcba,
  input  logic [w_digit-1:0] digit,
  input  logic [7:0]         ledr,
  input  logic [w_keys-1:0]  keys,
  input  logic [w_digit-1:0] blink,
  input  logic               ghost_en,
  input  logic [w_x-1:0]     x,
  input  logic [w_y-1:0]     y,
  input  logic               display_on,
  input  logic               frame_start,
  output logic [w_color-1:0] red,
  output logic [w_color-1:0] green,
  output logic [w_color-1:0] blue,
  output logic               rgb_valid
);

  localparam int cellsx = 8 * w_digit + 3;
  localparam int cellsy = 16;
  localparam int s      = $clog2(screen_width / cellsx) - 1;
  localparam int offx   = (screen_width - (cellsx << s)) / 2;
  localparam int offy   = (screen_height - (cellsy << s)) / 2;
  localparam int grid_w = 4 * w_digit + 1;
  localparam int grid_h = 8;
  localparam int dxw    = $clog2(grid_w);
  localparam int kw     = $clog2(key_hold_frames + 1);
  localparam int bw     = $clog2(blink_frames + 1);

  // Level for one cell, replicated onto the enabled channels {r,g,b}.
  function automatic logic [3*w_color-1:0] shade(input logic       pos_c,
                                                 input logic       lit_c,
                                                 input logic [2:0] chan_c,
                                                 input logic       ghost_c);
    logic [w_color-1:0] lvl;
    if (lit_c)                lvl = '1;
    else if (pos_c && ghost_c) lvl = w_color'(1);
    else                      lvl = '0;
    return {lvl & {w_color{chan_c[2]}},
            lvl & {w_color{chan_c[1]}},
            lvl & {w_color{chan_c[0]}}};
  endfunction

  // Panel state: live capture, per-frame snapshot, key hold, blink phase
  logic [7:0]         seg_live  [w_digit];
  logic [7:0]         seg_frame [w_digit];
  logic [7:0]         led_frame;
  logic [w_digit-1:0] blink_frame;
  logic [kw-1:0]      key_cnt   [w_keys];
  logic [bw-1:0]      blink_cnt;
  logic               phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < w_digit; i++) seg_live[i] <= '0;
    end else begin
      for (int i = 0; i < w_digit; i++)
        if (digit[i]) seg_live[i] <= hgfedcba;
    end
  end

  // The snapshot reads seg_live before this edge's capture, so a write
  // coinciding with frame_start only shows up in the following frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < w_digit; i++) seg_frame[i] <= '0;
      for (int k = 0; k < w_keys; k++)  key_cnt[k]   <= '0;
      led_frame   <= '0;
      blink_frame <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b1;
    end else if (frame_start) begin
      for (int i = 0; i < w_digit; i++) seg_frame[i] <= seg_live[i];
      led_frame   <= ledr;
      blink_frame <= blink;
      for (int k = 0; k < w_keys; k++) begin
        if (keys[k])                key_cnt[k] <= kw'(key_hold_frames);
        else if (key_cnt[k] != '0) key_cnt[k] <= key_cnt[k] - 1'b1;
      end
      if (blink_cnt == bw'(blink_frames - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Pixel to grid cell. Pixels left of / above the panel wrap to large
  // values and fall outside the grid. The dx/dy folding gives the narrow
  // gap columns/rows between the square cells.
  logic [w_x-1:0] xrel;
  logic [w_y-1:0] yrel;
  logic [w_x:0]   cx, dx_full;
  logic [w_y:0]   cy, dy_full;
  logic           in_grid;

  always_comb begin
    xrel    = x - w_x'(offx);
    yrel    = y - w_y'(offy);
    cx      = {1'b0, xrel >> s};
    cy      = {1'b0, yrel >> s};
    dx_full = (cx >> 2) + ((cx + 1'b1) >> 2);
    dy_full = (cy >> 2) + ((cy + 1'b1) >> 2);
    in_grid = (dx_full < (w_x+1)'(grid_w)) && (dy_full < (w_y+1)'(grid_h));
  end

  // ---- stage 1: grid coordinates and visibility ----
  logic [dxw-1:0] dx_p1;
  logic [2:0]     dy_p1;
  logic           in_p1, on_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_p1 <= '0;
      dy_p1 <= '0;
      in_p1 <= 1'b0;
      on_p1 <= 1'b0;
    end else begin
      dx_p1 <= dxw'(dx_full);
      dy_p1 <= dy_full[2:0];
      in_p1 <= in_grid;
      on_p1 <= display_on;
    end
  end

  // Cell decode: which digit column group the cell belongs to, the local
  // column (lc 0..3 = columns c0+1..c0+4) and the role of the cell.
  logic [dxw-1:0] col_m1, grp;
  logic [1:0]     lc;
  logic [7:0]     segs;
  logic           matched, has_led, has_key, led_b, key_b;
  logic           pos, lit;
  logic [2:0]     chan;

  always_comb begin
    col_m1  = dx_p1 - 1'b1;
    grp     = col_m1 >> 2;
    lc      = col_m1[1:0];
    segs    = '0;
    matched = 1'b0;
    has_led = 1'b0;
    has_key = 1'b0;
    led_b   = 1'b0;
    key_b   = 1'b0;
    pos     = 1'b0;
    lit     = 1'b0;
    chan    = 3'b111;
    for (int i = 0; i < w_digit; i++) begin
      if (dx_p1 != '0 && grp == dxw'(w_digit - 1 - i)) begin
        matched = 1'b1;
        // Blink blanks segments and dp only; LEDs and keys are unaffected.
        segs    = seg_frame[i] & {8{phase | ~blink_frame[i]}};
        has_led = (i < 8);
        led_b   = led_frame[i % 8];
        has_key = (i < w_keys);
        key_b   = (key_cnt[i % w_keys] != '0);
      end
    end
    case (dy_p1)
      3'd0: begin
        chan = 3'b110;
        if (has_led && lc != 2'd3) begin pos = 1'b1; lit = led_b; end
      end
      3'd1: begin
        if (dx_p1 != '0 && dx_p1 < dxw'(4 * w_digit)) begin pos = 1'b1; lit = 1'b1; end
      end
      3'd2: begin
        chan = 3'b101;
        if (has_key && lc != 2'd3) begin pos = 1'b1; lit = key_b; end
      end
      3'd3: if (matched && lc == 2'd1) begin pos = 1'b1; lit = segs[0]; end
      3'd4: begin
        if (matched && lc == 2'd0) begin pos = 1'b1; lit = segs[5]; end
        if (matched && lc == 2'd2) begin pos = 1'b1; lit = segs[1]; end
      end
      3'd5: if (matched && lc == 2'd1) begin pos = 1'b1; lit = segs[6]; end
      3'd6: begin
        if (matched && lc == 2'd0) begin pos = 1'b1; lit = segs[4]; end
        if (matched && lc == 2'd2) begin pos = 1'b1; lit = segs[2]; end
      end
      3'd7: begin
        if (matched && lc == 2'd1) begin pos = 1'b1; lit = segs[3]; end
        if (matched && lc == 2'd3) begin pos = 1'b1; lit = segs[7]; end
      end
      default: ;
    endcase
  end

  // ---- stage 2: colour and rgb_valid ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= on_p1;
      if (on_p1 && in_p1) {red, green, blue} <= shade(pos, lit, chan, ghost_en);
      else                {red, green, blue} <= '0;
    end
  end

endmodule

// File: tb/tb_virtual_tm1638_panel_renderer.sv
`timescale 1ns/1ps
// Testbench for virtual_tm1638_panel_renderer: directed scenarios from the
// panel's defined behaviour plus randomized back-to-back pixel streams
// checked against a cell-table reference model.
module tb_virtual_tm1638_panel_renderer;

  localparam int W_DIGIT = 8;
  localparam int W_KEYS  = 8;
  localparam int SW      = 640;
  localparam int SH      = 480;
  localparam int BF      = 2;
  localparam int KH      = 8;
  localparam int CELLSX  = 8 * W_DIGIT + 3;
  localparam int S       = $clog2(SW / CELLSX) - 1;
  localparam int OFFX    = (SW - (CELLSX << S)) / 2;
  localparam int OFFY    = (SH - (16 << S)) / 2;

  // {rgb_valid, red, green, blue}
  localparam logic [12:0] BLACK   = 13'h1000;
  localparam logic [12:0] WHITE   = 13'h1FFF;
  localparam logic [12:0] YELLOW  = 13'h1FF0;
  localparam logic [12:0] MAGENTA = 13'h1F0F;
  localparam logic [12:0] GHOSTW  = 13'h1111;
  localparam logic [12:0] GHOSTY  = 13'h1110;

  logic       clk;
  logic       rst;
  logic [7:0] hgfedcba, digit, ledr, keys, blink;
  logic       ghost_en, display_on, frame_start;
  logic [9:0] x;
  logic [8:0] y;
  logic [3:0] red, green, blue;
  logic       rgb_valid;

  int n_cmp = 0;
  int n_bad = 0;

  virtual_tm1638_panel_renderer #(
    .w_digit(W_DIGIT), .w_keys(W_KEYS), .screen_width(SW), .screen_height(SH),
    .w_color(4), .blink_frames(BF), .key_hold_frames(KH)
  ) dut (
    .clk(clk), .rst(rst), .hgfedcba(hgfedcba), .digit(digit), .ledr(ledr),
    .keys(keys), .blink(blink), .ghost_en(ghost_en), .x(x), .y(y),
    .display_on(display_on), .frame_start(frame_start),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time budget exceeded, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Segment cell positions relative to c0, bit order a,b,c,d,e,f,g,h.
  int SEG_COL [8] = '{2, 3, 3, 2, 1, 1, 2, 4};
  int SEG_ROW [8] = '{3, 4, 6, 7, 6, 4, 5, 7};

  logic [7:0] m_live [8];
  logic [7:0] m_seg  [8];
  logic [7:0] m_led, m_blink;
  int         m_key  [8];
  int         m_bcnt;
  bit         m_phase;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_live[i] = '0; m_seg[i] = '0; m_key[i] = 0;
    end
    m_led = '0; m_blink = '0; m_bcnt = 0; m_phase = 1'b1;
  endtask

  function automatic logic [12:0] exp_pixel(int px, int py, bit on);
    int cx, cy, dx, dy, c0;
    bit pos, lit;
    bit [2:0] ch;
    logic [3:0] lvl;
    if (!on) return 13'h0000;
    cx = ((px - OFFX) & 1023) >> S;
    cy = ((py - OFFY) & 511) >> S;
    dx = (cx >> 2) + ((cx + 1) >> 2);
    dy = (cy >> 2) + ((cy + 1) >> 2);
    if (dx >= 4 * W_DIGIT + 1 || dy >= 8) return BLACK;
    pos = 0; lit = 0; ch = 3'b111;
    if (dy == 0) ch = 3'b110;
    if (dy == 2) ch = 3'b101;
    if (dy == 1 && dx >= 1 && dx <= 4 * W_DIGIT - 1) begin pos = 1; lit = 1; end
    for (int i = 0; i < W_DIGIT; i++) begin
      c0 = (W_DIGIT - 1 - i) * 4;
      if (dy == 0 && dx >= c0 + 1 && dx <= c0 + 3) begin pos = 1; lit = m_led[i]; end
      if (dy == 2 && dx >= c0 + 1 && dx <= c0 + 3) begin pos = 1; lit = (m_key[i] != 0); end
      for (int b = 0; b < 8; b++)
        if (dx == c0 + SEG_COL[b] && dy == SEG_ROW[b]) begin
          pos = 1;
          lit = m_seg[i][b] && (m_phase || !m_blink[i]);
        end
    end
    lvl = lit ? 4'hF : ((pos && ghost_en) ? 4'h1 : 4'h0);
    return {1'b1, ch[2] ? lvl : 4'h0, ch[1] ? lvl : 4'h0, ch[0] ? lvl : 4'h0};
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic write_digit(input logic [7:0] mask, input logic [7:0] pat);
    @(negedge clk);
    digit = mask; hgfedcba = pat;
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (mask[i]) m_live[i] = pat;
    @(negedge clk);
    digit = '0;
  endtask

  task automatic frame_pulse(input logic [7:0] mask, input logic [7:0] pat);
    @(negedge clk);
    frame_start = 1'b1; digit = mask; hgfedcba = pat;
    @(posedge clk);
    for (int i = 0; i < 8; i++) m_seg[i] = m_live[i];
    m_led = ledr; m_blink = blink;
    for (int k = 0; k < 8; k++) begin
      if (keys[k]) m_key[k] = KH;
      else if (m_key[k] > 0) m_key[k] = m_key[k] - 1;
    end
    if (m_bcnt == BF - 1) begin m_bcnt = 0; m_phase = !m_phase; end
    else m_bcnt = m_bcnt + 1;
    for (int i = 0; i < 8; i++) if (mask[i]) m_live[i] = pat;
    @(negedge clk);
    frame_start = 1'b0; digit = '0;
  endtask

  task automatic get_pixel(input int px, input int py, input bit on, output logic [12:0] got);
    @(negedge clk);
    x = 10'(px); y = 9'(py); display_on = on;
    @(posedge clk);
    @(posedge clk);
    #1;
    got = {rgb_valid, red, green, blue};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [12:0] got;
    repeat (3) @(negedge clk);
    got = {rgb_valid, red, green, blue};
    n_cmp++;
    if (got !== 13'h0000) begin n_bad++; $display("FAIL reset_out: got %h required %h", got, 13'h0000); end
    @(negedge clk);
    rst = 1'b1;
    get_pixel(524, 200, 1, got);
    n_cmp++;
    if (got !== WHITE) begin n_bad++; $display("FAIL reset_separator: got %h required %h", got, WHITE); end
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL reset_segment: got %h required %h", got, BLACK); end
  endtask

  task automatic test_defaults();
    logic [12:0] got;
    write_digit(8'h80, 8'h01);
    frame_pulse(8'h00, 8'h00);
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== WHITE) begin n_bad++; $display("FAIL default_seg_a: got %h required %h", got, WHITE); end
    write_digit(8'h80, 8'h00);
    frame_pulse(8'h00, 8'h00);
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL default_cleared: got %h required %h", got, BLACK); end
    ghost_en = 1'b1;
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== GHOSTW) begin n_bad++; $display("FAIL default_ghost: got %h required %h", got, GHOSTW); end
    ghost_en = 1'b0;
  endtask

  task automatic test_led();
    logic [12:0] got;
    ledr = 8'h01;
    frame_pulse(8'h00, 8'h00);
    get_pixel(524, 180, 1, got);
    n_cmp++;
    if (got !== YELLOW) begin n_bad++; $display("FAIL led0_lit: got %h required %h", got, YELLOW); end
    get_pixel(10, 10, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL outside_panel: got %h required %h", got, BLACK); end
    get_pixel(524, 180, 0, got);
    n_cmp++;
    if (got !== 13'h0000) begin n_bad++; $display("FAIL display_off: got %h required %h", got, 13'h0000); end
    ghost_en = 1'b1;
    get_pixel(460, 180, 1, got);
    n_cmp++;
    if (got !== GHOSTY) begin n_bad++; $display("FAIL led1_ghost: got %h required %h", got, GHOSTY); end
    ghost_en = 1'b0;
    ledr = 8'h00;
  endtask

  task automatic test_tear();
    logic [12:0] got;
    write_digit(8'h80, 8'h01);
    frame_pulse(8'h00, 8'h00);
    write_digit(8'h80, 8'h00);
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== WHITE) begin n_bad++; $display("FAIL tear_midframe: got %h required %h", got, WHITE); end
    frame_pulse(8'h00, 8'h00);
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL tear_nextframe: got %h required %h", got, BLACK); end
    frame_pulse(8'h80, 8'h01);
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL tear_coincident: got %h required %h", got, BLACK); end
    frame_pulse(8'h00, 8'h00);
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== WHITE) begin n_bad++; $display("FAIL tear_after: got %h required %h", got, WHITE); end
  endtask

  task automatic test_key_hold();
    logic [12:0] got;
    keys = 8'h01;
    frame_pulse(8'h00, 8'h00);
    keys = 8'h00;
    for (int f = 1; f <= KH + 1; f++) begin
      if (f > 1) frame_pulse(8'h00, 8'h00);
      get_pixel(524, 208, 1, got);
      n_cmp++;
      if (got !== ((f <= KH) ? MAGENTA : BLACK)) begin
        n_bad++;
        $display("FAIL key_hold[frame %0d]: got %h required %h", f, got, (f <= KH) ? MAGENTA : BLACK);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] got;
    write_digit(8'h80, 8'h01);
    ledr = 8'h00; keys = 8'h00;
    frame_pulse(8'h00, 8'h00);
    @(negedge clk);
    x = 10'd84; y = 9'd232; display_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {rgb_valid, red, green, blue};
    n_cmp++;
    if (got !== WHITE) begin n_bad++; $display("FAIL pre_reset: got %h required %h", got, WHITE); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    got = {rgb_valid, red, green, blue};
    n_cmp++;
    if (got !== 13'h0000) begin n_bad++; $display("FAIL async_reset_immediate: got %h required %h", got, 13'h0000); end
    @(posedge clk);
    #1;
    got = {rgb_valid, red, green, blue};
    n_cmp++;
    if (got !== 13'h0000) begin n_bad++; $display("FAIL async_reset_held: got %h required %h", got, 13'h0000); end
    @(negedge clk);
    rst = 1'b1; display_on = 1'b0;
    model_reset();
    frame_pulse(8'h00, 8'h00);
    get_pixel(524, 200, 1, got);
    n_cmp++;
    if (got !== WHITE) begin n_bad++; $display("FAIL post_reset_separator: got %h required %h", got, WHITE); end
    get_pixel(84, 232, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL post_reset_segment: got %h required %h", got, BLACK); end
    get_pixel(524, 180, 1, got);
    n_cmp++;
    if (got !== BLACK) begin n_bad++; $display("FAIL post_reset_led: got %h required %h", got, BLACK); end
  endtask

  task automatic test_blink();
    logic [12:0] got, e;
    bit vis [8];
    bit bad;
    blink = 8'h80; ledr = 8'h80; ghost_en = 1'b0;
    write_digit(8'h80, 8'h01);
    for (int f = 0; f < 8; f++) begin
      frame_pulse(8'h00, 8'h00);
      e = exp_pixel(84, 232, 1);
      get_pixel(84, 232, 1, got);
      vis[f] = (got === WHITE);
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL blink_seg[frame %0d]: got %h required %h", f, got, e); end
      get_pixel(76, 180, 1, got);
      n_cmp++;
      if (got !== YELLOW) begin n_bad++; $display("FAIL blink_led[frame %0d]: got %h required %h", f, got, YELLOW); end
    end
    bad = 1'b0;
    for (int f = 0; f < 6; f++) if (vis[f] == vis[f + 2]) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL blink_period: got visibility %b%b%b%b%b%b%b%b, required runs of 2",
               vis[0], vis[1], vis[2], vis[3], vis[4], vis[5], vis[6], vis[7]);
    end
    blink = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [12:0] got, e;
    logic [12:0] expq [$];
    int px, py;
    bit on;
    for (int r = 0; r < 4; r++) begin
      ghost_en = 1'($urandom_range(0, 1));
      ledr     = 8'($urandom);
      blink    = 8'($urandom);
      keys     = 8'($urandom);
      for (int w = 0; w < 4; w++) write_digit(8'($urandom), 8'($urandom));
      frame_pulse(8'h00, 8'h00);
      keys = 8'($urandom);
      frame_pulse(8'($urandom), 8'($urandom));
      keys = 8'h00;
      frame_pulse(8'h00, 8'h00);
      expq.delete();
      for (int k = 0; k < 202; k++) begin
        @(negedge clk);
        if (k >= 2) begin
          got = {rgb_valid, red, green, blue};
          e   = expq.pop_front();
          n_cmp++;
          if (got !== e) begin
            n_bad++;
            $display("FAIL b2b[round %0d pixel %0d]: got %h required %h", r, k - 2, got, e);
          end
        end
        if (k < 200) begin
          if ($urandom_range(0, 3) == 0) begin
            px = int'($urandom_range(0, SW - 1));
            py = int'($urandom_range(0, SH - 1));
          end else begin
            px = int'($urandom_range(OFFX, OFFX + (CELLSX << S) - 1));
            py = int'($urandom_range(OFFY, OFFY + (16 << S) - 1));
          end
          on = ($urandom_range(0, 7) != 0);
          x = 10'(px); y = 9'(py); display_on = on;
          expq.push_back(exp_pixel(px, py, on));
        end else begin
          display_on = 1'b0;
        end
      end
    end
    ghost_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; hgfedcba = '0; digit = '0; ledr = '0; keys = '0; blink = '0;
    ghost_en = 1'b0; display_on = 1'b0; frame_start = 1'b0; x = '0; y = '0;
    model_reset();
    test_reset();
    test_defaults();
    test_led();
    test_tear();
    test_key_hold();
    test_async_reset();
    test_blink();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
